// File: rtl/sram_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller_pkg
// Description : Shared constants for the MEM-stage SRAM controller: SRAM bus
//               geometry, the byte address of SRAM location 0, and the 3-bit
//               FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_controller_pkg;

    localparam int SRAM_DQ_W   = 16;
    localparam int SRAM_ADDR_W = 18;
    localparam int BASE_ADDR   = 1024;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_RD_LO = 3'd1;
    localparam logic [2:0] c_ST_RD_HI = 3'd2;
    localparam logic [2:0] c_ST_WR_LO = 3'd3;
    localparam logic [2:0] c_ST_WR_HI = 3'd4;
    localparam logic [2:0] c_ST_DONE  = 3'd5;

endpackage : sram_controller_pkg
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : sram_controller
// Description : Splits one 32-bit word read/write from the MEM stage into two
//               16-bit accesses to an asynchronous SRAM (low half first), each
//               held for WAIT_CYCLES+1 cycles. ready=0 freezes the pipeline
//               until the access completes.
// Ports       : clk, rst          - clock, async active-high reset
//               rd_en, wr_en      - word read / write request (write wins)
//               addr, wdata       - byte address, write data
//               rdata, ready      - read data (valid in DONE), not-busy flag
//               SRAM_*            - SRAM pins (DQ tristate, strobes active-low)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int DATA_W      = 32,   // must equal 2*SRAM_DQ_W
    parameter int SRAM_DQ_W   = sram_controller_pkg::SRAM_DQ_W,
    parameter int SRAM_ADDR_W = sram_controller_pkg::SRAM_ADDR_W,
    parameter int BASE_ADDR   = sram_controller_pkg::BASE_ADDR,
    parameter int WAIT_CYCLES = 1     // 0..7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      addr,
    input  logic [DATA_W-1:0]      wdata,
    output logic [DATA_W-1:0]      rdata,
    output logic                   ready,
    inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N
);

    localparam int         c_IDX_W = SRAM_ADDR_W - 1;
    localparam logic [2:0] c_WAIT  = 3'(WAIT_CYCLES);

    logic [2:0]             r_state;
    logic [2:0]             w_next;
    logic [2:0]             r_cnt;
    logic [DATA_W-1:0]      r_wdata;
    logic [DATA_W-1:0]      r_rdata;
    logic [SRAM_ADDR_W-1:0] r_sram_addr;

    logic                   w_phase_end;
    logic                   w_in_phase;
    logic                   w_launch;
    logic                   w_drive;
    logic                   w_we_n;
    logic                   w_oe_n;
    logic                   w_ready;
    logic [SRAM_DQ_W-1:0]   w_dq_out;
    logic [c_IDX_W-1:0]     w_idx;

    // Word index inside the SRAM; addresses outside the window wrap silently.
    assign w_idx       = c_IDX_W'((addr - DATA_W'(BASE_ADDR)) >> 2);
    assign w_phase_end = (r_cnt == c_WAIT);
    assign w_in_phase  = (r_state == c_ST_RD_LO) || (r_state == c_ST_RD_HI) ||
                         (r_state == c_ST_WR_LO) || (r_state == c_ST_WR_HI);
    assign w_launch    = (r_state == c_ST_IDLE) && (w_next != c_ST_IDLE);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (wr_en) begin
                    w_next = c_ST_WR_LO;
                end else if (rd_en) begin
                    w_next = c_ST_RD_LO;
                end
            end
            c_ST_RD_LO: if (w_phase_end) w_next = c_ST_RD_HI;
            c_ST_RD_HI: if (w_phase_end) w_next = c_ST_DONE;
            c_ST_WR_LO: if (w_phase_end) w_next = c_ST_WR_HI;
            c_ST_WR_HI: if (w_phase_end) w_next = c_ST_DONE;
            // DONE always returns to IDLE, so the still-asserted request of
            // the completing instruction cannot start a second access.
            c_ST_DONE:  w_next = c_ST_IDLE;
            default:    w_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_ready  = 1'b0;
        w_we_n   = 1'b1;
        w_oe_n   = 1'b1;
        w_drive  = 1'b0;
        w_dq_out = '0;
        case (r_state)
            c_ST_IDLE: w_ready = ~rd_en & ~wr_en;
            c_ST_DONE: w_ready = 1'b1;
            c_ST_RD_LO, c_ST_RD_HI: w_oe_n = 1'b0;
            c_ST_WR_LO: begin
                // WE_N rises on the last cycle so data/address are held
                // across the write edge; with no wait states it stays low.
                w_we_n   = w_phase_end && (c_WAIT != 3'd0);
                w_drive  = 1'b1;
                w_dq_out = r_wdata[SRAM_DQ_W-1:0];
            end
            c_ST_WR_HI: begin
                w_we_n   = w_phase_end && (c_WAIT != 3'd0);
                w_drive  = 1'b1;
                w_dq_out = r_wdata[DATA_W-1:SRAM_DQ_W];
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: phase counter, request latch, SRAM address, read capture
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 3'd0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_sram_addr <= '0;
        end else begin
            if (w_next != r_state) begin
                r_cnt <= 3'd0;
            end else if (w_in_phase) begin
                r_cnt <= r_cnt + 3'd1;
            end

            if (w_launch) begin
                r_wdata     <= wdata;
                r_sram_addr <= {w_idx, 1'b0};
            end

            if (w_phase_end &&
                ((r_state == c_ST_RD_LO) || (r_state == c_ST_WR_LO))) begin
                r_sram_addr[0] <= 1'b1;
            end

            if (w_phase_end && (r_state == c_ST_RD_LO)) begin
                r_rdata[SRAM_DQ_W-1:0] <= SRAM_DQ;
            end
            if (w_phase_end && (r_state == c_ST_RD_HI)) begin
                r_rdata[DATA_W-1:SRAM_DQ_W] <= SRAM_DQ;
            end
        end
    end

    assign SRAM_DQ   = w_drive ? w_dq_out : {SRAM_DQ_W{1'bz}};
    assign SRAM_ADDR = r_sram_addr;
    assign SRAM_WE_N = w_we_n;
    assign SRAM_OE_N = w_oe_n;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign rdata     = r_rdata;
    assign ready     = w_ready;

endmodule : sram_controller
`default_nettype wire

// File: tb/tb_sram_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_controller
// Description : Self-checking bench for sram_controller. Two instances
//               (WAIT_CYCLES=1 and 0) each drive a behavioural async SRAM.
//               Directed cases plus randomized word traffic are compared with
//               a word-level memory model and latency/strobe expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_controller;

    localparam int c_W0 = 1;
    localparam int c_W1 = 0;
    localparam int c_MEM_N = 262144;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rd_en_t   [2];
    logic        wr_en_t   [2];
    logic [31:0] addr_t    [2];
    logic [31:0] wdata_t   [2];
    logic [31:0] rdata_t   [2];
    logic        ready_t   [2];
    logic [17:0] sram_addr_t [2];
    logic        we_n_t    [2];
    logic        oe_n_t    [2];
    logic        ub_n_t    [2];
    logic        lb_n_t    [2];
    logic        ce_n_t    [2];
    wire  [15:0] dq0;
    wire  [15:0] dq1;

    logic [15:0] mem [2][0:c_MEM_N-1];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cyc;
    logic [17:0] obs_first;
    logic [17:0] obs_last;
    logic [31:0] last_rd [2];
    logic [31:0] exp_mem [int];

    always @(posedge clk) cyc <= cyc + 1;

    sram_controller #(.WAIT_CYCLES(c_W0)) u_dut0 (
        .clk(clk), .rst(rst), .rd_en(rd_en_t[0]), .wr_en(wr_en_t[0]),
        .addr(addr_t[0]), .wdata(wdata_t[0]), .rdata(rdata_t[0]),
        .ready(ready_t[0]), .SRAM_DQ(dq0), .SRAM_ADDR(sram_addr_t[0]),
        .SRAM_UB_N(ub_n_t[0]), .SRAM_LB_N(lb_n_t[0]), .SRAM_CE_N(ce_n_t[0]),
        .SRAM_WE_N(we_n_t[0]), .SRAM_OE_N(oe_n_t[0])
    );

    sram_controller #(.WAIT_CYCLES(c_W1)) u_dut1 (
        .clk(clk), .rst(rst), .rd_en(rd_en_t[1]), .wr_en(wr_en_t[1]),
        .addr(addr_t[1]), .wdata(wdata_t[1]), .rdata(rdata_t[1]),
        .ready(ready_t[1]), .SRAM_DQ(dq1), .SRAM_ADDR(sram_addr_t[1]),
        .SRAM_UB_N(ub_n_t[1]), .SRAM_LB_N(lb_n_t[1]), .SRAM_CE_N(ce_n_t[1]),
        .SRAM_WE_N(we_n_t[1]), .SRAM_OE_N(oe_n_t[1])
    );

    // SRAM drives the bus only while output-enabled.
    assign dq0 = (oe_n_t[0] == 1'b0) ? mem[0][sram_addr_t[0]] : 16'hzzzz;
    assign dq1 = (oe_n_t[1] == 1'b0) ? mem[1][sram_addr_t[1]] : 16'hzzzz;

    function automatic logic [15:0] init_half(input int u, input int ha);
        return 16'(ha * 7 + 3) ^ ((u != 0) ? 16'h5A5A : 16'h0000);
    endfunction

    function automatic logic [16:0] word_idx(input logic [31:0] a);
        return 17'((a - 32'd1024) >> 2);
    endfunction

    function automatic int wait_of(input int u);
        return (u == 0) ? c_W0 : c_W1;
    endfunction

    function automatic int key_of(input int u, input logic [16:0] idx);
        return u * 32'h0010_0000 + int'(idx);
    endfunction

    function automatic logic [31:0] ref_word(input int u, input logic [16:0] idx);
        if (exp_mem.exists(key_of(u, idx)))
            return exp_mem[key_of(u, idx)];
        return {init_half(u, int'({idx, 1'b1})), init_half(u, int'({idx, 1'b0}))};
    endfunction

    // Behavioural SRAM: a level-sensitive write sampled mid-cycle.
    initial begin
        for (int i = 0; i < c_MEM_N; i++) begin
            mem[0][i] = init_half(0, i);
            mem[1][i] = init_half(1, i);
        end
        forever begin
            @(negedge clk);
            if (we_n_t[0] == 1'b0) mem[0][sram_addr_t[0]] = dq0;
            if (we_n_t[1] == 1'b0) mem[1][sram_addr_t[1]] = dq1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge with requests low.
    task automatic access(input int u, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
        int w, lat, we_low, we_pulse, oe_low, bus_err;
        logic prev_we;
        logic [16:0] idx;
        logic [15:0] dqv;
        logic [31:0] exp_rd;
        w = wait_of(u);
        idx = word_idx(a);
        lat = 0; we_low = 0; we_pulse = 0; oe_low = 0; bus_err = 0;
        prev_we = 1'b1;
        obs_first = '0;
        obs_last  = '0;
        rd_en_t[u] = rd; wr_en_t[u] = wr; addr_t[u] = a; wdata_t[u] = d;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ready_t[u]) break;
            dqv = (u == 0) ? dq0 : dq1;
            if (!we_n_t[u]) begin
                we_low++;
                if (prev_we) we_pulse++;
                if (dqv !== (sram_addr_t[u][0] ? d[31:16] : d[15:0])) bus_err++;
                if (!oe_n_t[u]) bus_err++;
            end
            prev_we = we_n_t[u];
            if (!oe_n_t[u]) oe_low++;
            if (lat == 1) obs_first = sram_addr_t[u];
            if (lat >= 1) obs_last = sram_addr_t[u];
            lat++;
            @(negedge clk);
        end
        done_cyc = cyc;
        check_eq("latency", lat, 2 * w + 3);
        check_eq("bus", bus_err, 0);
        check_eq("addr_lo", obs_first, {idx, 1'b0});
        check_eq("addr_hi", obs_last, {idx, 1'b1});
        if (wr) begin
            check_eq("we_low_cycles", we_low, (w == 0) ? 2 : 2 * w);
            check_eq("we_pulses", we_pulse, (w == 0) ? 1 : 2);
            check_eq("oe_in_write", oe_low, 0);
            check_eq("mem_lo", mem[u][{idx, 1'b0}], d[15:0]);
            check_eq("mem_hi", mem[u][{idx, 1'b1}], d[31:16]);
            check_eq("rdata_hold", rdata_t[u], last_rd[u]);
            exp_mem[key_of(u, idx)] = d;
        end else begin
            exp_rd = ref_word(u, idx);
            check_eq("rdata", rdata_t[u], exp_rd);
            check_eq("oe_low_cycles", oe_low, 2 * w + 2);
            check_eq("we_in_read", we_low, 0);
            last_rd[u] = exp_rd;
        end
        @(negedge clk);
        rd_en_t[u] = 1'b0;
        wr_en_t[u] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        int err;
        err = 0;
        for (int i = 0; i < n; i++) begin
            #1;
            for (int u = 0; u < 2; u++)
                if (!ready_t[u] || !we_n_t[u] || !oe_n_t[u]) err++;
            @(negedge clk);
        end
        if (n > 0) check_eq("idle", err, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, op, u_sel;
        logic [31:0] a, d;
        logic [16:0] ridx;
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            rd_en_t[u] = 1'b0; wr_en_t[u] = 1'b0;
            addr_t[u] = '0; wdata_t[u] = '0; last_rd[u] = '0;
        end
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_ready", ready_t[0], 1'b1);
        check_eq("rst_we_oe", {we_n_t[0], oe_n_t[0], we_n_t[1], oe_n_t[1]}, 4'hF);
        check_eq("rst_rdata", rdata_t[0], 32'h0);
        check_eq("rst_addr", sram_addr_t[0], 18'h0);
        check_eq("ties", {ub_n_t[0], lb_n_t[0], ce_n_t[0], ub_n_t[1], lb_n_t[1], ce_n_t[1]}, 0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        // Write then read on consecutive pipeline slots.
        access(0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        check_eq("mem2", mem[0][2], 16'hBEEF);
        check_eq("mem3", mem[0][3], 16'hDEAD);
        t1 = done_cyc;
        access(0, 1'b1, 1'b0, 32'd1028, 32'h0);
        check_eq("read_1028", rdata_t[0], 32'hDEADBEEF);
        check_eq("b2b_spacing", done_cyc - t1, 6);

        // Both requests: write wins, no read phase.
        access(0, 1'b1, 1'b1, 32'd1024, 32'h12345678);
        check_eq("mem0", mem[0][0], 16'h5678);
        check_eq("mem1", mem[0][1], 16'h1234);
        idle_cycles(2);

        // Asynchronous reset in the first WR_LO cycle.
        ridx = word_idx(32'd1024 + 4 * 500);
        rd_en_t[0] = 1'b0; wr_en_t[0] = 1'b1;
        addr_t[0] = 32'd1024 + 4 * 500; wdata_t[0] = 32'hCAFEF00D;
        @(negedge clk);
        #1;
        check_eq("wr_lo_we_active", we_n_t[0], 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_we", we_n_t[0], 1'b1);
        check_eq("rst_mid_oe", oe_n_t[0], 1'b1);
        check_eq("rst_mid_rdata", rdata_t[0], 32'h0);
        check_eq("rst_mid_addr", sram_addr_t[0], 18'h0);
        wr_en_t[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        exp_mem[key_of(0, ridx)] = {mem[0][{ridx, 1'b1}], mem[0][{ridx, 1'b0}]};
        #1;
        check_eq("ready_after_rst", ready_t[0], 1'b1);
        @(negedge clk);
        idle_cycles(1);

        // Randomized word traffic on both instances.
        for (int k = 0; k < 60; k++) begin
            u_sel = ((k % 4) == 3) ? 1 : 0;
            op = int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0)
                a = $urandom;
            else
                a = 32'd1024 + 4 * $urandom_range(0, 15);
            d = $urandom;
            access(u_sel, op != 1, op != 0, a, d);
            idle_cycles(int'($urandom_range(0, 2)));
        end

        // Zero-wait read at the top of the SRAM.
        access(1, 1'b1, 1'b0, 32'd1024 + 4 * (2 ** 17 - 1), 32'h0);
        check_eq("wrap_addr_lo", obs_first, 18'h3FFFE);
        check_eq("wrap_addr_hi", obs_last, 18'h3FFFF);
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sram_controller
`default_nettype wire
